div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/common_pkg.sv | 7 +
 rtl/pipes_pkg.sv | 17 +
 rtl/div.sv | 159 +++++++++++++++
 tb/tb_div.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared scalar types used across the execution pipes.
package common;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

endpackage

// File: rtl/pipes_pkg.sv
// Pipe-level types: divider FSM states and the word sign-extension helper.
package pipes;

    import common::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Sign-extend a 32-bit word result to 64 bits.
    function automatic u64 sext32(input u32 x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/div.sv
// Iterative RISC-V integer divider (DIV/DIVU/REM/REMU and W variants).
// One restoring shift-subtract step per cycle, MSB first.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The request side is accepted only in IDLE (in_ready = 1);
// the result side is held stable in DONE until out_valid && out_ready,
// after which the unit returns to IDLE on the next edge. flush aborts any
// transfer on the same edge; reset overrides everything.
module div
    import common::*;
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        is_signed,
    input  logic        is_word,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic [1:0]  state_dbg
);

    div_state_t state, state_nxt;

    // Working registers: partial remainder, dividend/quotient shift register,
    // divisor magnitude, step counter and latched result signs.
    u64         rem_q;
    u64         quo_q;
    u64         dvsr_q;
    logic [5:0] cnt_q;
    logic       word_q;
    logic       neg_q_q;
    logic       neg_r_q;

    // Accept-time operand decode.
    logic a_neg, b_neg, div_zero, overflow;
    u64   a_mag, b_mag, quo_init;
    u64   spec_q, spec_r;
    u32   a_lo_neg, b_lo_neg;

    // Step datapath.
    logic [64:0] shifted, diff;
    u64          step_rem, step_quo;
    u64          q_fix64, r_fix64;
    u32          q_fix32, r_fix32;
    u64          final_q, final_r;
    logic        last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    // Decode operands at accept: magnitudes, signs and the two special cases.
    always_comb begin
        a_lo_neg = -a[31:0];
        b_lo_neg = -b[31:0];
        a_neg    = is_signed & (is_word ? a[31] : a[63]);
        b_neg    = is_signed & (is_word ? b[31] : b[63]);
        if (is_word) begin
            a_mag    = a_neg ? {32'b0, a_lo_neg} : {32'b0, a[31:0]};
            b_mag    = b_neg ? {32'b0, b_lo_neg} : {32'b0, b[31:0]};
            quo_init = {a_mag[31:0], 32'b0};
            div_zero = (b[31:0] == 32'b0);
            overflow = is_signed && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
            spec_r   = sext32(a[31:0]);
        end else begin
            a_mag    = a_neg ? -a : a;
            b_mag    = b_neg ? -b : b;
            quo_init = a_mag;
            div_zero = (b == 64'b0);
            overflow = is_signed && (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
            spec_r   = a;
        end
        // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
        spec_q = div_zero ? 64'hFFFF_FFFF_FFFF_FFFF : spec_r;
        if (!div_zero) spec_r = 64'b0;
    end

    // One restoring step plus sign fix-up of the result it would produce.
    always_comb begin
        shifted   = {rem_q, quo_q[63]};
        diff      = shifted - {1'b0, dvsr_q};
        step_rem  = diff[64] ? shifted[63:0] : diff[63:0];
        step_quo  = {quo_q[62:0], ~diff[64]};
        q_fix64   = neg_q_q ? -step_quo : step_quo;
        r_fix64   = neg_r_q ? -step_rem : step_rem;
        q_fix32   = neg_q_q ? -step_quo[31:0] : step_quo[31:0];
        r_fix32   = neg_r_q ? -step_rem[31:0] : step_rem[31:0];
        final_q   = word_q ? sext32(q_fix32) : q_fix64;
        final_r   = word_q ? sext32(r_fix32) : r_fix64;
        last_step = (cnt_q == (word_q ? 6'd31 : 6'd63));
    end

    // Next-state logic; flush forces IDLE over accept and handoff.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (div_zero || overflow) ? DONE : CALC;
            CALC: if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State, working registers and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        rem_q   <= '0;
                        quo_q   <= quo_init;
                        dvsr_q  <= b_mag;
                        cnt_q   <= '0;
                        word_q  <= is_word;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        if (div_zero || overflow) begin
                            quotient  <= spec_q;
                            remainder <= spec_r;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 6'd1;
                        if (last_step) begin
                            quotient  <= final_q;
                            remainder <= final_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed and random bench for the iterative divider, with a result
// scoreboard and latency/handshake checks.
module tb_div;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        is_signed;
    logic        is_word;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic [1:0]  state_dbg;

    logic [63:0] exp_q[$];
    logic [63:0] exp_r[$];
    int          checks = 0;
    int          errors = 0;

    div dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .is_word   (is_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model written with the language's own division operators.
    function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        a32 = ma[31:0];
        b32 = mb[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (mb == 64'd0) begin
                q = '1; r = ma;
            end else if (s && ma == 64'h8000_0000_0000_0000 && mb == '1) begin
                q = ma; r = 64'd0;
            end else if (s) begin
                q = $signed(ma) / $signed(mb);
                r = $signed(ma) % $signed(mb);
            end else begin
                q = ma / mb;
                r = ma % mb;
            end
        end
    endfunction

    // Drive one request, wait for its result, compare, then hand off.
    // Expected values must already be queued.
    task automatic run_core(input logic [63:0] da, input logic [63:0] db,
                            input logic s, input logic w, input int hold);
        int lat;
        int exp_lat;
        logic [63:0] eq, er;
        if (w) exp_lat = (db[31:0] == 0 || (s && da[31:0] == 32'h8000_0000 && db[31:0] == 32'hFFFF_FFFF)) ? 1 : 33;
        else   exp_lat = (db == 0 || (s && da == 64'h8000_0000_0000_0000 && db == '1)) ? 1 : 65;
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a = da; b = db; is_signed = s; is_word = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom(); b = $urandom();
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_handoff_valid", {63'd0, out_valid}, 64'd0);
        check("post_handoff_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_exp(input logic [63:0] da, input logic [63:0] db,
                           input logic s, input logic w,
                           input logic [63:0] eq, input logic [63:0] er, input int hold);
        exp_q.push_back(eq);
        exp_r.push_back(er);
        run_core(da, db, s, w, hold);
    endtask

    task automatic run_model(input logic [63:0] da, input logic [63:0] db,
                             input logic s, input logic w);
        logic [63:0] eq, er;
        model(da, db, s, w, eq, er);
        exp_q.push_back(eq);
        exp_r.push_back(er);
        run_core(da, db, s, w, 0);
    endtask

    // Start 100/7, abort it at cycle 10 of CALC with flush or reset, and
    // confirm no result ever appears.
    task automatic abort_test(input logic use_reset);
        int seen;
        a = 64'd100; b = 64'd7; is_signed = 1'b0; is_word = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        check(use_reset ? "abort_reset_ready" : "abort_flush_ready", {63'd0, in_ready}, 64'd1);
        check(use_reset ? "abort_reset_valid" : "abort_flush_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
    endtask

    // Directed stimulus sequence.
    initial begin
        logic [63:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        is_word = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        check("reset_state", {62'd0, state_dbg}, 64'd0);

        run_exp(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 0);
        run_exp(-64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_exp(64'd5, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
        run_exp(64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
        run_exp(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                64'h8000_0000_0000_0000, 64'd0, 0);
        run_exp(64'h1_FFFF_FFFF, 64'h1_0000_0002, 1'b0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 0);
        run_exp(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
                64'hFFFF_FFFF_8000_0000, 64'd0, 0);
        run_exp(64'h0000_0000_FFFF_FFF9, 64'h0000_0000_0000_0000, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 0);
        run_exp(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_exp(64'd7, -64'sd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 0);
        run_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 1'b0, 1'b0, 64'h1999_9999_9999_9999, 64'd5, 0);
        // Result held with out_ready low for ten cycles.
        run_exp(64'd1000, 64'd33, 1'b0, 1'b0, 64'd30, 64'd10, 10);

        // flush alongside a request in IDLE: nothing is accepted.
        a = 64'd9; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {63'd0, in_ready}, 64'd1);

        abort_test(1'b0);
        run_exp(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 0);
        abort_test(1'b1);
        run_exp(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 0);

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()} >> $urandom_range(0, 60);
            run_model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
